// File: rtl/alu_result_buffer.sv
// alu_result_buffer
// Two-entry result FIFO between the shifter/ALU and register writeback.
// Each entry carries {result, z, n, dest}. The architectural Z/N flags are
// updated from the entry at the moment it is written back (popped), and a
// sticky error flag records any popped entry whose Z/N disagree with its
// own result value.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid & ready are both 1. in_ready depends only on the current occupancy
// and rst (never on out_ready), so a full buffer refuses a push even in a
// cycle where it is also being popped. out_* are driven from storage only,
// never combinationally from in_*.

module alu_result_buffer #(
  parameter int WIDTH  = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_result,
  input  logic              in_z,
  input  logic              in_n,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_err,
  output logic [1:0]        count
);

  // Control state (reset)
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_err_q, flag_err_d;

  // Entry storage (no reset; only read when the slot is occupied)
  logic [WIDTH-1:0]  res_q  [2];
  logic [WIDTH-1:0]  res_d  [2];
  logic              z_q    [2];
  logic              z_d    [2];
  logic              n_q    [2];
  logic              n_d    [2];
  logic [DEST_W-1:0] dest_q [2];
  logic [DEST_W-1:0] dest_d [2];

  // Handshake and head-entry view
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  head_res;
  logic              head_z;
  logic              head_n;
  logic [DEST_W-1:0] head_dest;
  logic              head_inconsistent;

  // Handshake decode and the oldest entry as seen through the read pointer
  always_comb begin
    in_ready  = (count_q < 2'd2) && !rst;
    out_valid = (count_q != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;

    head_res  = res_q[rd_ptr_q];
    head_z    = z_q[rd_ptr_q];
    head_n    = n_q[rd_ptr_q];
    head_dest = dest_q[rd_ptr_q];

    // Z must mean "result is zero" and N must equal the result's sign bit
    head_inconsistent = (head_z != (head_res == '0)) ||
                        (head_n != head_res[WIDTH-1]);
  end

  // Next pointers, occupancy and architectural flags
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    flag_z_d   = flag_z_q;
    flag_n_d   = flag_n_q;
    flag_err_d = flag_err_q;

    // 1-bit pointers wrap 1 -> 0 naturally
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;

    // push is impossible at 2 and pop impossible at 0, so no saturation needed
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      flag_z_d = head_z;
      flag_n_d = head_n;
      if (head_inconsistent) flag_err_d = 1'b1;
    end
  end

  // Next storage contents: only the slot under the write pointer changes
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      res_d[i]  = res_q[i];
      z_d[i]    = z_q[i];
      n_d[i]    = n_q[i];
      dest_d[i] = dest_q[i];
      if (push && (wr_ptr_q == 1'(i))) begin
        res_d[i]  = in_result;
        z_d[i]    = in_z;
        n_d[i]    = in_n;
        dest_d[i] = in_dest;
      end
    end
  end

  // Control registers, cleared asynchronously so outputs drop immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flag_z_q   <= flag_z_d;
      flag_n_q   <= flag_n_d;
      flag_err_q <= flag_err_d;
    end
  end

  // Entry storage registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      res_q[i]  <= res_d[i];
      z_q[i]    <= z_d[i];
      n_q[i]    <= n_d[i];
      dest_q[i] <= dest_d[i];
    end
  end

  // Output view: data fields read as zero while the buffer is empty
  always_comb begin
    out_result = out_valid ? head_res  : '0;
    out_dest   = out_valid ? head_dest : '0;
    flag_z     = flag_z_q;
    flag_n     = flag_n_q;
    flag_err   = flag_err_q;
    count      = count_q;
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer
// Directed scenarios followed by randomized traffic, all checked every
// cycle against a queue-based model of the buffer.

module tb_alu_result_buffer;

  localparam int W  = 32;
  localparam int DW = 5;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_result = '0;
  logic          in_z = 1'b0;
  logic          in_n = 1'b0;
  logic [DW-1:0] in_dest = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic [DW-1:0] out_dest;
  logic          flag_z;
  logic          flag_n;
  logic          flag_err;
  logic [1:0]    count;

  always #5 clk = ~clk;

  alu_result_buffer #(.WIDTH(W), .DEST_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_z       (in_z),
    .in_n       (in_n),
    .in_dest    (in_dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dest   (out_dest),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_err   (flag_err),
    .count      (count)
  );

  // ---------------- counters and check helper ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [W-1:0]  r;
    logic          z;
    logic          n;
    logic [DW-1:0] d;
  } ent_t;

  ent_t m_q[$];
  logic m_fz  = 1'b0;
  logic m_fn  = 1'b0;
  logic m_err = 1'b0;

  // Model: at most two entries held; a full buffer never accepts, a pop
  // hands the oldest entry to the flags.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_fz  = 1'b0;
      m_fn  = 1'b0;
      m_err = 1'b0;
    end else begin
      bit   do_push;
      bit   do_pop;
      ent_t e;
      do_push = in_valid && (m_q.size() < 2);
      do_pop  = out_ready && (m_q.size() > 0);
      if (do_pop) begin
        e = m_q.pop_front();
        m_fz = e.z;
        m_fn = e.n;
        if ((e.z != (e.r == 0)) || (e.n != e.r[W-1])) m_err = 1'b1;
      end
      if (do_push) m_q.push_back('{r: in_result, z: in_z, n: in_n, d: in_dest});
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    int sz;
    sz = m_q.size();
    chk("count",      64'(count),      64'(sz));
    chk("out_valid",  64'(out_valid),  64'(sz > 0));
    chk("in_ready",   64'(in_ready),   64'((sz < 2) && !rst));
    chk("out_result", 64'(out_result), 64'(sz > 0 ? m_q[0].r : '0));
    chk("out_dest",   64'(out_dest),   64'(sz > 0 ? m_q[0].d : '0));
    chk("flag_z",     64'(flag_z),     64'(m_fz));
    chk("flag_n",     64'(flag_n),     64'(m_fn));
    chk("flag_err",   64'(flag_err),   64'(m_err));
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  // Push request with Z/N derived from the value
  task automatic set_in(input logic v, input logic [W-1:0] r, input logic [DW-1:0] d);
    in_valid  = v;
    in_result = r;
    in_z      = (r == 0);
    in_n      = r[W-1];
    in_dest   = d;
  endtask

  // Push request with explicit Z/N
  task automatic set_raw(input logic [W-1:0] r, input logic z, input logic n, input logic [DW-1:0] d);
    in_valid  = 1'b1;
    in_result = r;
    in_z      = z;
    in_n      = n;
    in_dest   = d;
  endtask

  logic [W-1:0] got_q[$];

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    cycle();
    cycle();
    chk("rst_count",    64'(count),      64'd0);
    chk("rst_out_valid",64'(out_valid),  64'd0);
    chk("rst_in_ready", 64'(in_ready),   64'd0);
    chk("rst_out_res",  64'(out_result), 64'd0);
    chk("rst_flags",    64'({flag_z, flag_n, flag_err}), 64'd0);
    rst = 1'b0;

    // Single pass
    out_ready = 1'b1;
    set_raw(32'h8000_0000, 1'b0, 1'b1, 5'd3);
    cycle();
    set_in(1'b0, '0, '0);
    chk("sp_valid",  64'(out_valid),  64'd1);
    chk("sp_result", 64'(out_result), 64'h8000_0000);
    chk("sp_dest",   64'(out_dest),   64'd3);
    cycle();
    chk("sp_flag_n", 64'(flag_n), 64'd1);
    chk("sp_flag_z", 64'(flag_z), 64'd0);
    chk("sp_count",  64'(count),  64'd0);

    // Backpressure
    out_ready = 1'b0;
    set_in(1'b1, 32'h1, 5'd1); cycle();
    set_in(1'b1, 32'h2, 5'd2); cycle();
    set_in(1'b1, 32'h3, 5'd3); cycle();
    chk("bp_count",    64'(count),      64'd2);
    chk("bp_in_ready", 64'(in_ready),   64'd0);
    chk("bp_head",     64'(out_result), 64'h1);
    out_ready = 1'b1;
    cycle();
    set_in(1'b0, '0, '0);
    chk("bp_head2",  64'(out_result), 64'h2);
    chk("bp_count1", 64'(count),      64'd1);
    cycle();
    chk("bp_empty",  64'(count),      64'd0);

    // Simultaneous push and pop at count 1
    out_ready = 1'b0;
    set_in(1'b1, 32'h5, 5'd5); cycle();
    chk("sim_head5", 64'(out_result), 64'h5);
    out_ready = 1'b1;
    set_in(1'b1, 32'h6, 5'd6); cycle();
    set_in(1'b0, '0, '0);
    chk("sim_count", 64'(count),      64'd1);
    chk("sim_head6", 64'(out_result), 64'h6);
    chk("sim_flags", 64'({flag_z, flag_n}), 64'd0);
    cycle();

    // Consistency error is sticky
    set_raw(32'h0, 1'b0, 1'b0, 5'd7); cycle();
    set_in(1'b0, '0, '0); cycle();
    chk("err_set", 64'(flag_err), 64'd1);
    set_in(1'b1, 32'h9, 5'd9); cycle();
    set_in(1'b0, '0, '0); cycle();
    chk("err_sticky", 64'(flag_err), 64'd1);

    // Reset mid-operation with a full buffer
    out_ready = 1'b0;
    set_in(1'b1, 32'hA, 5'd1); cycle();
    set_in(1'b1, 32'hB, 5'd2); cycle();
    set_in(1'b0, '0, '0);
    chk("rm_full", 64'(count), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("rm_count",    64'(count),     64'd0);
    chk("rm_valid",    64'(out_valid), 64'd0);
    chk("rm_in_ready", 64'(in_ready),  64'd0);
    chk("rm_err",      64'(flag_err),  64'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("rm_ready_back", 64'(in_ready), 64'd1);
    set_in(1'b1, 32'h7, 5'd7); cycle();
    set_in(1'b0, '0, '0);
    chk("rm_first_valid", 64'(out_valid),  64'd1);
    chk("rm_first_res",   64'(out_result), 64'h7);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // Wrap-around with alternating out_ready
    begin
      int k;
      k = 0;
      got_q.delete();
      for (int c = 0; c < 30; c++) begin
        bit fire;
        out_ready = c[0];
        if (k < 5) set_in(1'b1, 32'h10 + 32'(k), 5'(k));
        else       set_in(1'b0, '0, '0);
        fire = in_valid && in_ready;
        if (out_valid && out_ready) got_q.push_back(out_result);
        cycle();
        if (fire) k++;
        chk("wrap_cnt_le2", 64'(count <= 2'd2), 64'd1);
      end
      set_in(1'b0, '0, '0);
      chk("wrap_n_out", 64'(got_q.size()), 64'd5);
      for (int i = 0; i < 5 && i < got_q.size(); i++)
        chk("wrap_order", 64'(got_q[i]), 64'h10 + 64'(i));
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [W-1:0] r;
      logic         z;
      logic         n;
      case ($urandom_range(0, 9))
        0:       r = '0;
        1:       r = 32'h8000_0000 | $urandom();
        default: r = $urandom();
      endcase
      z = (r == 0);
      n = r[W-1];
      if ($urandom_range(0, 59) == 0) z = ~z;
      if ($urandom_range(0, 59) == 0) n = ~n;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_result = r;
      in_z      = z;
      in_n      = n;
      in_dest   = DW'($urandom());
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    set_in(1'b0, '0, '0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter WIDTH, default 32: width of the result data path.
REQ-002 Parameter DEST_W, default 5: width of the destination register index.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  shifter/ALU result presented this cycle.
REQ-006 in_ready  output  1  buffer can accept an entry this cycle.
REQ-007 in_result  input  WIDTH  shifter result B.
REQ-008 in_z  input  1  zero flag Z from the shifter.
REQ-009 in_n  input  1  negative flag N from the shifter.
REQ-010 in_dest  input  DEST_W  destination register index.
REQ-011 out_valid  output  1  head entry available for writeback.
REQ-012 out_ready  input  1  writeback consumes the head entry this cycle.
REQ-013 out_result  output  WIDTH  head entry result.
REQ-014 out_dest  output  DEST_W  head entry destination.
REQ-015 flag_z  output  1  architectural Z flag, last popped entry.
REQ-016 flag_n  output  1  architectural N flag, last popped entry.
REQ-017 flag_err  output  1  sticky flag-consistency error.
REQ-018 count  output  2  number of occupied entries, 0..2.

Function
REQ-019 The block SHALL be a 2-entry FIFO of {result, z, n, dest}.
- Push occurs when in_valid & in_ready.
- Pop occurs when out_valid & out_ready.
REQ-020 in_ready SHALL be 1 exactly when count < 2 and rst is low, with no combinational path from out_ready.
REQ-021 out_valid SHALL be 1 exactly when count > 0, and the out_* fields SHALL present the oldest entry.
REQ-022 Latency SHALL be 1 cycle: an entry pushed into an empty buffer appears on out_* on the following cycle.
REQ-023 Simultaneous push and pop with count=1 SHALL leave count at 1, with the new entry becoming the head.
REQ-024 With count=2, in_valid SHALL be ignored (no push) even if a pop occurs in the same cycle.
REQ-025 Pop with count=0 SHALL NOT occur (out_valid=0), and count SHALL never underflow or exceed 2.
REQ-026 Read/write pointers SHALL be 1 bit each and wrap 1 to 0.
REQ-027 On each pop, flag_z and flag_n SHALL load the popped entry's z and n on that clock edge; otherwise they hold.
REQ-028 On each pop, flag_err SHALL set if popped z != (result == 0) or popped n != result[WIDTH-1].
- It stays set until reset.
REQ-029 The out_* fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 FIFO data storage SHALL NOT need reset, but out_result/out_dest SHALL read 0 when count=0.

Reset
REQ-031 rst=1 SHALL immediately (asynchronously) force count=0, pointers=0, out_valid=0, in_ready=0, flag_z=0, flag_n=0, flag_err=0, out_result=0, out_dest=0.
REQ-032 rst asserted mid-operation SHALL discard all stored entries; in_ready SHALL return to 1 in the first cycle after rst deasserts.

Verification
REQ-033 Single pass: after reset push {0x80000000, z=0, n=1, dest=3}, out_ready=1 -> next cycle out_valid=1, out_result=0x80000000, out_dest=3; after pop flag_n=1, flag_z=0, count=0.
REQ-034 Backpressure: out_ready=0, push 0x1, 0x2, then offer 0x3 -> count=2, in_ready=0, 0x3 not accepted; release out_ready -> pops 0x1 then 0x2 in order.
REQ-035 Simultaneous: count=1 holding 0x5, push 0x6 and pop in the same cycle -> count stays 1, head=0x6, flag_z=0, flag_n=0.
REQ-036 Consistency: push {0x00000000, z=0, n=0} and pop -> flag_err=1; subsequent consistent pops keep flag_err=1 until rst.
REQ-037 Reset mid-operation: count=2, assert rst between clock edges -> out_valid=0 and count=0 immediately; after release, first push of 0x7 emerges one cycle later.
REQ-038 Wrap-around: push/pop 5 entries 0x10..0x14 with alternating out_ready -> output order matches input, count never exceeds 2.
